// File: rtl/ddr_read_arbiter_pkg.sv
// Shared definitions for the DDR read arbiter: FSM encoding and beat size.
package ddr_read_arbiter_pkg;

    localparam int unsigned FIFO_DATA_LEN_DFLT = 128;
    localparam int unsigned BEAT_BYTES         = FIFO_DATA_LEN_DFLT / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ddr_read_arbiter_if.sv
// DDR reader side of the arbiter: command channel plus read-FIFO pop port.
interface ddr_read_arbiter_if
    import ddr_read_arbiter_pkg::*;
#(
    parameter int unsigned DDR_ADDR_LEN  = 32,
    parameter int unsigned SINGLE_LEN    = 24,
    parameter int unsigned FIFO_DATA_LEN = BEAT_BYTES * 8
);
    logic                     ddr_conf;
    logic [DDR_ADDR_LEN-1:0]  ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]    ddr_len;
    logic                     ddr_fifo_empty;
    logic                     ddr_fifo_req;
    logic [FIFO_DATA_LEN-1:0] ddr_fifo_data;

    modport master (
        output ddr_conf, ddr_st_addr_out, ddr_len, ddr_fifo_req,
        input  ddr_fifo_empty, ddr_fifo_data
    );

    modport slave (
        input  ddr_conf, ddr_st_addr_out, ddr_len, ddr_fifo_req,
        output ddr_fifo_empty, ddr_fifo_data
    );
endinterface

// File: rtl/ddr_read_arbiter_rr_pick.sv
// Round-robin winner selection: search starts just after the last grant.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] winner
);
    int unsigned idx;
    logic        found;

    // First pending requester at (last_grant+1), (last_grant+2), ... wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (!found && pending[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ddr_read_arbiter.sv
// Arbitrates buffer-fill read requests onto a single DDR reader and routes
// its read FIFO to the current owner.
module ddr_read_arbiter
    import ddr_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ         = 3,
    parameter int unsigned DDR_ADDR_LEN  = 32,
    parameter int unsigned SINGLE_LEN    = 24,
    parameter int unsigned FIFO_DATA_LEN = BEAT_BYTES * 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_conf,
    input  logic [N_REQ*DDR_ADDR_LEN-1:0] req_addr,
    input  logic [N_REQ*SINGLE_LEN-1:0]   req_len,
    output logic [N_REQ-1:0]              req_fifo_empty,
    input  logic [N_REQ-1:0]              req_fifo_req,
    output logic [FIFO_DATA_LEN-1:0]      req_fifo_data,
    output logic [N_REQ-1:0]              req_done,
    ddr_read_arbiter_if.master            ddr,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          err_overlap
);
    localparam int unsigned IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BEAT_SHIFT = $clog2(FIFO_DATA_LEN / 8);

    arb_state_t             state, state_nxt;
    logic [N_REQ-1:0]       pending;
    logic [DDR_ADDR_LEN-1:0] lat_addr [N_REQ];
    logic [SINGLE_LEN-1:0]  lat_len  [N_REQ];
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       winner_idx;
    logic [N_REQ-1:0]       winner;
    logic [SINGLE_LEN-1:0]  count;
    logic [SINGLE_LEN-1:0]  beats;
    logic [SINGLE_LEN-1:0]  beats_m1;
    logic                   start_arb, issue_cmd, issue_zero, beat, finish;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Shift plus remainder-OR keeps the ceiling inside SINGLE_LEN bits.
    assign beats    = (ddr.ddr_len >> BEAT_SHIFT)
                    + SINGLE_LEN'(|ddr.ddr_len[BEAT_SHIFT-1:0]);
    assign beats_m1 = beats - SINGLE_LEN'(1);

    assign busy          = (state != ST_IDLE);
    assign req_fifo_data = ddr.ddr_fifo_data;
    assign ddr.ddr_fifo_req = (state == ST_STREAM) ? req_fifo_req[owner] : 1'b0;

    // Convert the one-hot winner to an index for the owner register.
    always_comb begin
        winner_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner[i]) winner_idx = IDX_W'(i);
        end
    end

    // Only the owner sees the real empty flag, and only while streaming.
    always_comb begin
        req_fifo_empty = '1;
        if (state == ST_STREAM) req_fifo_empty[owner] = ddr.ddr_fifo_empty;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and one-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        start_arb  = 1'b0;
        issue_cmd  = 1'b0;
        issue_zero = 1'b0;
        beat       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    start_arb = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lat_len[owner] == '0) begin
                    issue_zero = 1'b1;
                    state_nxt  = ST_IDLE;
                end else begin
                    issue_cmd = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                beat = ddr.ddr_fifo_req && !ddr.ddr_fifo_empty;
                if (beat && (count == beats_m1)) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; completion clear is applied last, and any conf for a
    // still-pending slot is dropped, so set and clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            err_overlap <= 1'b0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                lat_addr[i] <= '0;
                lat_len[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_conf[i]) begin
                    if (pending[i]) begin
                        err_overlap <= 1'b1;
                    end else begin
                        pending[i]  <= 1'b1;
                        lat_addr[i] <= req_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                        lat_len[i]  <= req_len[i*SINGLE_LEN +: SINGLE_LEN];
                    end
                end
            end
            if (finish || issue_zero) pending[owner] <= 1'b0;
        end
    end

    // Grant bookkeeping and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            req_done   <= '0;
        end else begin
            req_done <= '0;
            if (start_arb) begin
                grant <= winner;
                owner <= winner_idx;
            end else if (finish || issue_zero) begin
                req_done   <= grant;
                grant      <= '0;
                last_grant <= owner;
            end
        end
    end

    // DDR command registers; address/length stay valid for the whole stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddr.ddr_conf        <= 1'b0;
            ddr.ddr_st_addr_out <= '0;
            ddr.ddr_len         <= '0;
        end else begin
            ddr.ddr_conf <= issue_cmd;
            if (issue_cmd) begin
                ddr.ddr_st_addr_out <= lat_addr[owner];
                ddr.ddr_len         <= lat_len[owner];
            end
        end
    end

    // Beat counter, restarted for each issued command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  count <= '0;
        else if (state == ST_ISSUE)  count <= '0;
        else if (beat && !finish)    count <= count + SINGLE_LEN'(1);
    end
endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Self-checking bench for ddr_read_arbiter with a transfer scoreboard.
module tb_ddr_read_arbiter;
    localparam int N = 3;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [23:0] len;
    } xfer_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    req_conf;
    logic [95:0]   req_addr;
    logic [71:0]   req_len;
    logic [2:0]    req_fifo_empty;
    logic [2:0]    req_fifo_req;
    logic [127:0]  req_fifo_data;
    logic [2:0]    req_done;
    logic [2:0]    grant;
    logic          busy;
    logic          err_overlap;

    int total = 0;
    int bad   = 0;
    xfer_t cmd_q[$];
    xfer_t done_q[$];

    ddr_read_arbiter_if #(.DDR_ADDR_LEN(32), .SINGLE_LEN(24), .FIFO_DATA_LEN(128)) dif ();

    ddr_read_arbiter #(
        .N_REQ(3), .DDR_ADDR_LEN(32), .SINGLE_LEN(24), .FIFO_DATA_LEN(128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_conf       (req_conf),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_fifo_empty (req_fifo_empty),
        .req_fifo_req   (req_fifo_req),
        .req_fifo_data  (req_fifo_data),
        .req_done       (req_done),
        .ddr            (dif),
        .grant          (grant),
        .busy           (busy),
        .err_overlap    (err_overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        req_conf = '0;
        req_fifo_req = '0;
        dif.ddr_fifo_empty = 1'b1;
        dif.ddr_fifo_data = '0;
        cmd_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs the DDR/requester side until every expected completion is seen.
    // Called right after a negedge, before this cycle's inputs are driven.
    task automatic drain(input int budget, input bit gap, input logic [2:0] hold,
                         input bit toggle, input int inject);
        bit         active = 0;
        bit         due = 0;
        int         cur = 0;
        int         left = 0;
        int         cyc = 0;
        bit         injected = 0;
        bit         empty;
        xfer_t      t;
        logic [2:0] req;
        logic [2:0] exp_empty;
        logic       exp_freq;
        while (done_q.size() != 0 && cyc < budget) begin
            if (dif.ddr_conf === 1'b1) begin
                total++;
                if (cmd_q.size() == 0) begin
                    bad++;
                    $display("FAIL cmd_unexpected: ddr_conf addr=%h len=%0d, none expected",
                             dif.ddr_st_addr_out, dif.ddr_len);
                end else begin
                    t = cmd_q.pop_front();
                    if (dif.ddr_st_addr_out !== t.addr || dif.ddr_len !== t.len ||
                        grant !== 3'(1 << t.idx)) begin
                        bad++;
                        $display("FAIL cmd: addr=%h len=%0d grant=%b, want addr=%h len=%0d grant=%b",
                                 dif.ddr_st_addr_out, dif.ddr_len, grant, t.addr, t.len, 3'(1 << t.idx));
                    end
                    active = 1;
                    cur = t.idx;
                    left = (int'(t.len) + 15) / 16;
                end
            end
            if (due) begin
                total++;
                t = done_q.pop_front();
                if (req_done !== 3'(1 << cur) || t.idx != cur) begin
                    bad++;
                    $display("FAIL done_pulse: req_done=%b, want %b (expected owner %0d)",
                             req_done, 3'(1 << cur), t.idx);
                end
                due = 0;
            end else if (req_done !== 3'b000) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: req_done=%b, want 000", req_done);
                end else begin
                    t = done_q.pop_front();
                    if (t.len !== 24'd0 || req_done !== 3'(1 << t.idx)) begin
                        bad++;
                        $display("FAIL done_early: req_done=%b, want 000 (beats left %0d)", req_done, left);
                    end
                end
            end
            req = hold;
            if (active && left > 0 && (!gap || (cyc % 2) == 0)) req[cur] = 1'b1;
            empty = toggle ? ((cyc % 2) == 1) : 1'b0;
            dif.ddr_fifo_empty = empty;
            dif.ddr_fifo_data = {$urandom, $urandom, $urandom, $urandom};
            req_fifo_req = req;
            if (inject >= 0 && active && !injected) begin
                req_conf = 3'(1 << inject);
                req_addr[inject*32 +: 32] = 32'hDEAD_0000;
                req_len[inject*24 +: 24] = 24'd16;
                injected = 1;
            end else begin
                req_conf = '0;
            end
            #1;
            exp_freq = active ? req[cur] : 1'b0;
            exp_empty = '1;
            if (active) exp_empty[cur] = empty;
            total++;
            if (dif.ddr_fifo_req !== exp_freq || req_fifo_empty !== exp_empty) begin
                bad++;
                $display("FAIL route: ddr_fifo_req=%b req_fifo_empty=%b, want %b %b",
                         dif.ddr_fifo_req, req_fifo_empty, exp_freq, exp_empty);
            end
            total++;
            if (req_fifo_data !== dif.ddr_fifo_data) begin
                bad++;
                $display("FAIL data: req_fifo_data=%h, want %h", req_fifo_data, dif.ddr_fifo_data);
            end
            if (active) begin
                total++;
                if (grant !== 3'(1 << cur)) begin
                    bad++;
                    $display("FAIL grant_hold: grant=%b, want %b", grant, 3'(1 << cur));
                end
            end
            if (active && req[cur] && !empty) begin
                left--;
                if (left == 0) begin
                    due = 1;
                    active = 0;
                end
            end
            cyc++;
            @(negedge clk);
        end
        req_fifo_req = '0;
        req_conf = '0;
        total++;
        if (done_q.size() != 0 || cmd_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d completions and %0d commands outstanding, want 0 0",
                     done_q.size(), cmd_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 3'b000 || busy !== 1'b0 || req_done !== 3'b000 || err_overlap !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: grant=%b busy=%b done=%b err=%b, want 000 0 000 0",
                     grant, busy, req_done, err_overlap);
        end
        total++;
        if (dif.ddr_conf !== 1'b0 || dif.ddr_st_addr_out !== 32'h0 || dif.ddr_len !== 24'h0 ||
            dif.ddr_fifo_req !== 1'b0 || req_fifo_empty !== 3'b111) begin
            bad++;
            $display("FAIL reset_ddr: conf=%b addr=%h len=%h freq=%b empty=%b, want 0 0 0 0 111",
                     dif.ddr_conf, dif.ddr_st_addr_out, dif.ddr_len, dif.ddr_fifo_req, req_fifo_empty);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int lat;
        apply_reset();
        cmd_q.push_back('{idx: 0, addr: 32'h1000, len: 24'd64});
        done_q.push_back('{idx: 0, addr: 32'h1000, len: 24'd64});
        req_addr[31:0] = 32'h1000;
        req_len[23:0] = 24'd64;
        req_conf = 3'b001;
        @(negedge clk);
        req_conf = '0;
        lat = 1;
        while (dif.ddr_conf !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL conf_latency: %0d cycles, want 3", lat);
        end
        drain(200, 0, 3'b000, 0, -1);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*32 +: 32] = 32'h2000 + 32'(i) * 32'h100;
            req_len[i*24 +: 24] = 24'd16;
            cmd_q.push_back('{idx: i, addr: 32'h2000 + 32'(i) * 32'h100, len: 24'd16});
            done_q.push_back('{idx: i, addr: 32'h2000 + 32'(i) * 32'h100, len: 24'd16});
        end
        req_conf = 3'b111;
        @(negedge clk);
        req_conf = '0;
        drain(200, 0, 3'b000, 0, -1);
        // last grant was requester 2, so 0 is ahead of 1
        req_addr[31:0] = 32'h3000;
        req_addr[63:32] = 32'h3100;
        cmd_q.push_back('{idx: 0, addr: 32'h3000, len: 24'd16});
        cmd_q.push_back('{idx: 1, addr: 32'h3100, len: 24'd16});
        done_q.push_back('{idx: 0, addr: 32'h3000, len: 24'd16});
        done_q.push_back('{idx: 1, addr: 32'h3100, len: 24'd16});
        req_conf = 3'b011;
        @(negedge clk);
        req_conf = '0;
        drain(200, 0, 3'b000, 0, -1);
    endtask

    task automatic test_rounding();
        apply_reset();
        req_addr[31:0] = 32'h4000;
        req_len[23:0] = 24'd20;
        req_addr[63:32] = 32'h5000;
        req_len[47:24] = 24'd0;
        cmd_q.push_back('{idx: 0, addr: 32'h4000, len: 24'd20});
        done_q.push_back('{idx: 0, addr: 32'h4000, len: 24'd20});
        done_q.push_back('{idx: 1, addr: 32'h5000, len: 24'd0});
        req_conf = 3'b011;
        @(negedge clk);
        req_conf = '0;
        drain(200, 0, 3'b000, 0, -1);
    endtask

    task automatic test_nonowner();
        apply_reset();
        req_addr[31:0] = 32'h6000;
        req_len[23:0] = 24'd48;
        cmd_q.push_back('{idx: 0, addr: 32'h6000, len: 24'd48});
        done_q.push_back('{idx: 0, addr: 32'h6000, len: 24'd48});
        req_conf = 3'b001;
        @(negedge clk);
        req_conf = '0;
        drain(200, 1, 3'b110, 0, -1);
    endtask

    task automatic test_toggle_empty();
        apply_reset();
        req_addr[95:64] = 32'h7000;
        req_len[71:48] = 24'd80;
        cmd_q.push_back('{idx: 2, addr: 32'h7000, len: 24'd80});
        done_q.push_back('{idx: 2, addr: 32'h7000, len: 24'd80});
        req_conf = 3'b100;
        @(negedge clk);
        req_conf = '0;
        drain(200, 0, 3'b000, 1, -1);
    endtask

    task automatic test_overlap();
        bit idle_ok = 1;
        apply_reset();
        req_addr[63:32] = 32'h8000;
        req_len[47:24] = 24'd64;
        cmd_q.push_back('{idx: 1, addr: 32'h8000, len: 24'd64});
        done_q.push_back('{idx: 1, addr: 32'h8000, len: 24'd64});
        req_conf = 3'b010;
        @(negedge clk);
        req_conf = '0;
        drain(200, 0, 3'b000, 0, 1);
        total++;
        if (err_overlap !== 1'b1) begin
            bad++;
            $display("FAIL overlap_flag: err_overlap=%b, want 1", err_overlap);
        end
        repeat (6) begin
            if (busy !== 1'b0 || dif.ddr_conf !== 1'b0 || req_done !== 3'b000) idle_ok = 0;
            @(negedge clk);
        end
        total++;
        if (!idle_ok) begin
            bad++;
            $display("FAIL overlap_ignored: activity after dropped conf, want idle");
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit quiet = 1;
        apply_reset();
        req_addr[95:64] = 32'hABCD_0000;
        req_len[71:48] = 24'hFFFFFF;
        req_conf = 3'b100;
        @(negedge clk);
        req_conf = '0;
        while (dif.ddr_conf !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dif.ddr_conf !== 1'b1 || dif.ddr_len !== 24'hFFFFFF || dif.ddr_st_addr_out !== 32'hABCD_0000) begin
            bad++;
            $display("FAIL max_len_cmd: conf=%b len=%h addr=%h, want 1 ffffff abcd0000",
                     dif.ddr_conf, dif.ddr_len, dif.ddr_st_addr_out);
        end
        dif.ddr_fifo_empty = 1'b0;
        req_fifo_req = 3'b100;
        req_conf = 3'b100;
        @(negedge clk);
        req_conf = '0;
        repeat (3) @(negedge clk);
        total++;
        if (err_overlap !== 1'b1 || req_done !== 3'b000 || busy !== 1'b1 || grant !== 3'b100) begin
            bad++;
            $display("FAIL mid_stream: err=%b done=%b busy=%b grant=%b, want 1 000 1 100",
                     err_overlap, req_done, busy, grant);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 3'b000 || busy !== 1'b0 || err_overlap !== 1'b0 || dif.ddr_fifo_req !== 1'b0 ||
            req_fifo_empty !== 3'b111 || dif.ddr_len !== 24'h0 || dif.ddr_st_addr_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: grant=%b busy=%b err=%b freq=%b empty=%b len=%h addr=%h, want 000 0 0 0 111 0 0",
                     grant, busy, err_overlap, dif.ddr_fifo_req, req_fifo_empty, dif.ddr_len, dif.ddr_st_addr_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_fifo_req = '0;
        repeat (8) begin
            @(negedge clk);
            if (req_done !== 3'b000 || dif.ddr_conf !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL reset_abandon: activity after reset, want no done/conf/busy");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_conf = '0;
        req_addr = '0;
        req_len = '0;
        req_fifo_req = '0;
        dif.ddr_fifo_empty = 1'b1;
        dif.ddr_fifo_data = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_rounding();
        test_nonowner();
        test_toggle_empty();
        test_overlap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
